onchip_mem_dp: RTL

ONCHIP_MEM_DP -- requirements
Module: onchip_mem_dp

---
 rtl/onchip_mem_dp.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/onchip_mem_dp.sv
// Dual-port on-chip RAM with Avalon-MM style slave ports, a post-reset clear sweep,
// optional debug-only write protection and a 1- or 2-stage read return pipeline.
module onchip_mem_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter bit PROTECT        = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  output logic                    init_done,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic                    s1_debugaccess,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic                    s2_debugaccess,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;
  localparam logic RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic                  state_r;
  logic [ADDR_WIDTH-1:0] clr_addr_r;
  logic                  init_done_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  wait_s;
  logic [ADDR_WIDTH-1:0] addr_s  [2];
  logic [NB-1:0]         be_s    [2];
  logic [DATA_WIDTH-1:0] wdata_s [2];
  logic [DATA_WIDTH-1:0] rword_s [2];
  logic [1:0]            cs_s, rd_s, wr_s, dbg_s;
  logic [1:0]            acc_rd_s, acc_wr_s, allow_s, commit_s;

  logic [1:0]            pipe_v_r, rvalid_r;
  logic [DATA_WIDTH-1:0] pipe_d_r [2];
  logic [DATA_WIDTH-1:0] rdata_r  [2];

  assign addr_s[0]  = s1_address;    assign addr_s[1]  = s2_address;
  assign be_s[0]    = s1_byteenable; assign be_s[1]    = s2_byteenable;
  assign wdata_s[0] = s1_writedata;  assign wdata_s[1] = s2_writedata;
  assign cs_s  = {s2_chipselect, s1_chipselect};
  assign rd_s  = {s2_read, s1_read};
  assign wr_s  = {s2_write, s1_write};
  assign dbg_s = {s2_debugaccess, s1_debugaccess};

  // Asynchronous array read; the registered pipeline captures it before any same-edge write lands.
  assign rword_s[0] = mem_r[addr_s[0]];
  assign rword_s[1] = mem_r[addr_s[1]];

  assign wait_s           = (state_r == ST_CLEAR) | ~clken;
  assign s1_waitrequest   = wait_s;
  assign s2_waitrequest   = wait_s;
  assign init_done        = init_done_r;
  assign s1_readdata      = rdata_r[0];
  assign s2_readdata      = rdata_r[1];
  assign s1_readdatavalid = rvalid_r[0];
  assign s2_readdatavalid = rvalid_r[1];

  // Accept and commit decode; a same-address collision lets s1 win outright.
  always_comb begin
    acc_rd_s = 2'b00;
    acc_wr_s = 2'b00;
    allow_s  = 2'b00;
    commit_s = 2'b00;
    for (int p = 0; p < 2; p++) begin
      acc_wr_s[p] = cs_s[p] & wr_s[p] & ~wait_s;
      acc_rd_s[p] = cs_s[p] & rd_s[p] & ~wr_s[p] & ~wait_s;
      allow_s[p]  = acc_wr_s[p] & (~PROTECT | dbg_s[p]);
    end
    commit_s[0] = allow_s[0];
    if (allow_s[0] && (addr_s[0] == addr_s[1])) begin
      commit_s[1] = 1'b0;
    end else begin
      commit_s[1] = allow_s[1];
    end
  end

  // Clear sequencer: sweeps every address once after reset, then hands over to normal traffic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= RESET_STATE;
      clr_addr_r  <= {ADDR_WIDTH{1'b0}};
      init_done_r <= 1'b0;
    end else if (clken) begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_addr_r == LAST_ADDR) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
            clr_addr_r  <= {ADDR_WIDTH{1'b0}};
          end else begin
            clr_addr_r  <= clr_addr_r + ADDR_ONE;
          end
        end
        ST_RUN:  init_done_r <= 1'b1;
        default: begin
          state_r     <= RESET_STATE;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Array update: zero fill while clearing, otherwise byte-lane writes from committed ports.
  always_ff @(posedge clk) begin
    if (clken && reset_n) begin
      if (state_r == ST_CLEAR) begin
        mem_r[clr_addr_r] <= {DATA_WIDTH{1'b0}};
      end else begin
        for (int p = 0; p < 2; p++) begin
          for (int b = 0; b < NB; b++) begin
            if (commit_s[p] && be_s[p][b]) begin
              mem_r[addr_s[p]][b*8 +: 8] <= wdata_s[p][b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read return pipeline; everything holds while clken is low so in-flight valids resume later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v_r <= 2'b00;
      rvalid_r <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        pipe_d_r[p] <= {DATA_WIDTH{1'b0}};
        rdata_r[p]  <= {DATA_WIDTH{1'b0}};
      end
    end else if (clken) begin
      pipe_v_r <= acc_rd_s;
      for (int p = 0; p < 2; p++) begin
        pipe_d_r[p] <= rword_s[p];
        if (READ_LATENCY == 1) begin
          rvalid_r[p] <= acc_rd_s[p];
          if (acc_rd_s[p]) rdata_r[p] <= rword_s[p];
        end else begin
          rvalid_r[p] <= pipe_v_r[p];
          if (pipe_v_r[p]) rdata_r[p] <= pipe_d_r[p];
        end
      end
    end
  end

endmodule
